// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encoding, frame-field widths, the default frame start byte and the
// checksum helper.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } loader_state_t;

    // Default frame start byte.
    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Word-count field is two bytes on the wire.
    localparam int LEN_W = 16;

    // Byte lane counter width (four lanes per 32-bit word).
    localparam int LANE_W = 2;
    localparam logic [LANE_W-1:0] LAST_LANE = 2'd3;

    // Frame checksum is a plain running XOR of the data bytes.
    function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                               input logic [7:0] data_byte);
        return csum ^ data_byte;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words. Bytes arrive lane 0
// first; on the fourth byte word_valid pulses combinationally with the full
// word (the fourth byte bypasses the shift register), so the caller can
// register the word on the same edge that accepts that byte.
module imem_boot_loader_byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;

    // Lane counter and right-shifting byte register; clear wins over data.
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            lane_d  = lane_q + LANE_W'(1);
            shift_d = {byte_data, shift_q[23:8]};
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid = byte_valid && !clear && (lane_q == LAST_LANE);
    assign word_data  = {byte_data, shift_q};

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte image from the host link, writes it
// word by word into instruction memory and releases the core from reset
// only once the whole image has arrived with a matching checksum.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | hunting for the frame start byte, other bytes dropped
// S_LEN0  | waiting for word-count low byte
// S_LEN1  | waiting for word-count high byte, range check
// S_DATA  | packing data bytes, one write cycle after each full word
// S_CSUM  | waiting for the checksum byte
// S_DONE  | image accepted, core released (terminal)
// S_ERROR | frame rejected, core held (terminal)
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    // A full memory (2**ADDR_W words) is still a legal image.
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

    loader_state_t     state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic              rx_ready_q, rx_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              load_done_q, load_done_d;
    logic              load_error_q, load_error_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;

    logic              accept;
    logic [LEN_W-1:0]  len_full;
    logic              pack_clear;
    logic              pack_valid;
    logic              word_valid;
    logic [31:0]       word_data;

    assign accept     = rx_valid && rx_ready_q;
    assign len_full   = {rx_data, len_lo_q};
    // Only data bytes go to the packer; it is held empty outside S_DATA so
    // every image starts on lane 0.
    assign pack_clear = (state_q != S_DATA);
    assign pack_valid = accept && (state_q == S_DATA);

    imem_boot_loader_byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear),
        .byte_valid (pack_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_d        = state_q;
        len_lo_d       = len_lo_q;
        len_d          = len_q;
        csum_d         = csum_q;
        rx_ready_d     = rx_ready_q;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        core_hold_d    = core_hold_q;
        load_done_d    = load_done_q;
        load_error_d   = load_error_q;
        words_loaded_d = words_loaded_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && (rx_data == MAGIC)) begin
                    state_d = S_LEN0;
                    csum_d  = '0;
                end
            end

            S_LEN0: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end

            S_LEN1: begin
                if (accept) begin
                    len_d = len_full[ADDR_W:0];
                    if ({16'h0000, len_full} > MAX_WORDS) begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                        rx_ready_d   = 1'b0;
                    end else if (len_full == '0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (imem_we_q) begin
                    // Write cycle: reopen the link and move to the next word,
                    // or leave for the checksum once the last word is out.
                    // The address is left on the last word written.
                    rx_ready_d = 1'b1;
                    if (words_loaded_q == len_q) begin
                        state_d = S_CSUM;
                    end else begin
                        imem_addr_d = imem_addr_q + ADDR_W'(1);
                    end
                end else if (accept) begin
                    csum_d = csum_update(csum_q, rx_data);
                    if (word_valid) begin
                        imem_we_d      = 1'b1;
                        imem_wdata_d   = word_data;
                        words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
                        rx_ready_d     = 1'b0;
                    end
                end
            end

            S_CSUM: begin
                if (accept) begin
                    rx_ready_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d     = S_DONE;
                        load_done_d = 1'b1;
                        core_hold_d = 1'b0;
                    end else begin
                        state_d      = S_ERROR;
                        load_error_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                rx_ready_d = 1'b0;
            end

            S_ERROR: begin
                rx_ready_d = 1'b0;
            end

            default: begin
                state_d      = S_ERROR;
                load_error_d = 1'b1;
                rx_ready_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            len_lo_q       <= '0;
            len_q          <= '0;
            csum_q         <= '0;
            rx_ready_q     <= 1'b1;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            core_hold_q    <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            csum_q         <= csum_d;
            rx_ready_q     <= rx_ready_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            core_hold_q    <= core_hold_d;
            load_done_q    <= load_done_d;
            load_error_q   <= load_error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign core_hold    = core_hold_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: frames are built from byte images, the
// expected memory writes are queued as each word is issued and a separate
// monitor pops and compares them as imem_we strobes appear.
module tb_imem_boot_loader;

    localparam int         ADDR_W    = 10;
    localparam logic [7:0] MAGIC     = 8'hA5;
    localparam int         MAX_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;

    // Expected writes: {address, word}.
    logic [ADDR_W+31:0] exp_q[$];
    // Image bytes and leading junk for the next frame.
    logic [7:0]         img[$];
    logic [7:0]         junk_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation
    // and strobes must never be back to back.
    initial begin
        logic               prev_we;
        logic [ADDR_W+31:0] e;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                check("we_gap", 32'(prev_we), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(imem_addr), 32'(e[ADDR_W+31:32]));
                    check("write_data", imem_wdata, e[31:0]);
                end
            end
            prev_we = imem_we;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the rising edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input bit throttle);
        int guard;
        int gap;
        if (throttle) begin
            gap = int'($urandom_range(0, 3));
            for (int i = 0; i < gap; i++) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout actual=%0b expected=1", rx_ready);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic fill_img(input int n);
        img.delete();
        for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    endtask

    // Sends junk_q, then a frame of word count n built from img, and checks
    // the terminal outputs against what the frame rules predict.
    task automatic run_frame(input string tag, input logic [15:0] n,
                             input bit bad_csum, input bit throttle);
        logic [7:0]  x;
        logic [7:0]  cs;
        bit          legal;
        bit          exp_ok;
        legal = (int'(n) <= MAX_WORDS);
        x = 8'h00;
        if (legal) foreach (img[i]) x = x ^ img[i];
        cs     = bad_csum ? (x ^ 8'h01) : x;
        exp_ok = legal && !bad_csum;

        foreach (junk_q[i]) send_byte(junk_q[i], throttle);
        send_byte(MAGIC, throttle);
        send_byte(n[7:0], throttle);
        send_byte(n[15:8], throttle);
        if (legal) begin
            for (int w = 0; w < int'(n); w++) begin
                exp_q.push_back({ADDR_W'(w), img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]});
                for (int l = 0; l < 4; l++) send_byte(img[4*w+l], throttle);
            end
            send_byte(cs, throttle);
        end
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 32'(load_done), 32'(exp_ok));
        check({tag, "_error"}, 32'(load_error), 32'(!exp_ok));
        check({tag, "_core_hold"}, 32'(core_hold), 32'(!exp_ok));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), legal ? 32'(n) : 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        junk_q.delete();
    endtask

    task automatic load_frame1();
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    endtask

    initial begin
        do_reset();

        // Two-word image; its checksum (XOR of the data bytes) is 0x90.
        load_frame1();
        run_frame("f1", 16'd2, 1'b0, 1'b0);

        // Junk before the start byte is dropped.
        do_reset();
        load_frame1();
        junk_q = '{8'h00, 8'hFF};
        run_frame("junk", 16'd2, 1'b0, 1'b0);

        // Wrong checksum: words still written, frame rejected.
        do_reset();
        load_frame1();
        run_frame("badcs", 16'd2, 1'b1, 1'b0);

        // Empty image and an over-long word count.
        do_reset();
        img.delete();
        run_frame("n0", 16'd0, 1'b0, 1'b0);
        do_reset();
        img.delete();
        run_frame("toolong", 16'h0401, 1'b0, 1'b0);

        // Randomly throttled frames of random size and checksum validity.
        for (int t = 0; t < 10; t++) begin
            int n;
            n = int'($urandom_range(1, 8));
            do_reset();
            fill_img(n);
            run_frame("rand", 16'(n), ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Reset after five data bytes, then the full frame again.
        do_reset();
        load_frame1();
        send_byte(MAGIC, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_q.push_back({ADDR_W'(0), 32'h00000013});
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b0);
        check("mid_words", 32'(words_loaded), 32'd1);
        do_reset();
        load_frame1();
        run_frame("reload", 16'd2, 1'b0, 1'b0);

        // Full-depth image.
        do_reset();
        fill_img(MAX_WORDS);
        run_frame("full", 16'(MAX_WORDS), 1'b0, 1'b0);
        check("full_last_addr", 32'(imem_addr), 32'(MAX_WORDS - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
